// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the LCD parallel-bus read and write paths:
// read FSM encoding, status bit positions and default bus timing.
package lcd_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } lcd_rd_state_e;

  localparam int unsigned LCD_STATUS_BUSY_BIT = 7;

  localparam int unsigned LCD_T_AS  = 1;
  localparam int unsigned LCD_T_RD  = 4;
  localparam int unsigned LCD_T_AH  = 1;
  localparam int unsigned LCD_T_REC = 2;

  // Phase timer width; every timing constant must be <= 2**LCD_PHASE_W.
  localparam int unsigned LCD_PHASE_W = 8;

  function automatic logic [LCD_PHASE_W-1:0] phase_load(input int unsigned cycles);
    return LCD_PHASE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_bus_reader_timer.sv
// Loadable down-counter with a zero flag; times each bus phase.
module lcd_phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side master for the 8080-style LCD bus: single status/data reads or
// repeated status polling until the busy bit clears. All outputs registered.
module lcd_bus_reader
  import lcd_bus_pkg::*;
#(
  parameter int unsigned T_AS     = LCD_T_AS,
  parameter int unsigned T_RD     = LCD_T_RD,
  parameter int unsigned T_AH     = LCD_T_AH,
  parameter int unsigned T_REC    = LCD_T_REC,
  parameter int unsigned BUSY_BIT = LCD_STATUS_BUSY_BIT,
  parameter int unsigned POLL_MAX = 255,
  parameter int unsigned PCW      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_a0,
  input  logic           req_poll,
  output logic           rsp_valid,
  output logic [7:0]     rsp_data,
  output logic           rsp_timeout,
  output logic [PCW-1:0] poll_count,
  input  logic [7:0]     data_i,
  output logic           cs_n,
  output logic           rd_n,
  output logic           wr_n,
  output logic           a0,
  output logic           bus_busy
);

  lcd_rd_state_e state_q, state_d;
  logic cs_n_q, cs_n_d, rd_n_q, rd_n_d, a0_q, a0_d;
  logic req_ready_q, req_ready_d, bus_busy_q, bus_busy_d;
  logic rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [7:0] rsp_data_q, rsp_data_d, shadow_q, shadow_d;
  logic [PCW-1:0] poll_count_q, poll_count_d;
  logic poll_q, poll_d, done_q, done_d;
  logic phase_load_en, phase_zero, busy_seen, at_max;
  logic [LCD_PHASE_W-1:0] phase_val;

  lcd_phase_timer #(.W(LCD_PHASE_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (phase_load_en),
    .load_val_i(phase_val),
    .zero_o    (phase_zero)
  );

  assign busy_seen = poll_q && shadow_q[BUSY_BIT];
  assign at_max    = (poll_count_q == PCW'(POLL_MAX));

  always_comb begin
    state_d       = state_q;
    a0_d          = a0_q;
    poll_d        = poll_q;
    poll_count_d  = poll_count_q;
    shadow_d      = shadow_q;
    done_d        = done_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    phase_val     = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d      = ST_SETUP;
          a0_d         = req_poll ? 1'b0 : req_a0;
          poll_d       = req_poll;
          poll_count_d = '0;
          done_d       = 1'b0;
        end
      end
      ST_SETUP: if (phase_zero) state_d = ST_STROBE;
      ST_STROBE: begin
        if (phase_zero) begin
          state_d  = ST_HOLD;
          shadow_d = data_i;
          if (!at_max) poll_count_d = poll_count_q + PCW'(1);
        end
      end
      ST_HOLD: begin
        // Response decision is taken on entry to RECOVER and remembered in done.
        if (phase_zero) begin
          state_d = ST_RECOVER;
          done_d  = !busy_seen || at_max;
          if (!busy_seen || at_max) begin
            rsp_valid_d   = 1'b1;
            rsp_data_d    = shadow_q;
            rsp_timeout_d = busy_seen;
          end
        end
      end
      ST_RECOVER: if (phase_zero) state_d = done_q ? ST_IDLE : ST_SETUP;
      default: state_d = ST_IDLE;
    endcase

    phase_load_en = (state_d != state_q);
    case (state_d)
      ST_SETUP:   phase_val = phase_load(T_AS);
      ST_STROBE:  phase_val = phase_load(T_RD);
      ST_HOLD:    phase_val = phase_load(T_AH);
      ST_RECOVER: phase_val = phase_load(T_REC);
      default:    phase_val = '0;
    endcase

    cs_n_d      = !(state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
    rd_n_d      = (state_d != ST_STROBE);
    bus_busy_d  = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cs_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      a0_q          <= 1'b0;
      req_ready_q   <= 1'b0;
      bus_busy_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      poll_count_q  <= '0;
      poll_q        <= 1'b0;
      shadow_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_n_q        <= cs_n_d;
      rd_n_q        <= rd_n_d;
      a0_q          <= a0_d;
      req_ready_q   <= req_ready_d;
      bus_busy_q    <= bus_busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      poll_count_q  <= poll_count_d;
      poll_q        <= poll_d;
      shadow_q      <= shadow_d;
      done_q        <= done_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign poll_count  = poll_count_q;
  assign cs_n        = cs_n_q;
  assign rd_n        = rd_n_q;
  assign wr_n        = 1'b1;
  assign a0          = a0_q;
  assign bus_busy    = bus_busy_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: default instance plus a POLL_MAX=3 instance.
module tb_lcd_bus_reader;
  import lcd_bus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req_valid, req_a0, req_poll, sel, mon_en, poll_seq;
  logic [7:0] data_drv;
  logic req_valid_a, req_valid_b;
  logic req_ready_a, rsp_valid_a, rsp_timeout_a, cs_n_a, rd_n_a, wr_n_a, a0_a, bus_busy_a;
  logic req_ready_b, rsp_valid_b, rsp_timeout_b, cs_n_b, rd_n_b, wr_n_b, a0_b, bus_busy_b;
  logic [7:0] rsp_data_a, poll_count_a, rsp_data_b, poll_count_b;
  logic m_req_ready, m_rsp_valid, m_rsp_timeout, m_cs_n, m_rd_n, m_a0, m_bus_busy;
  logic [7:0] m_rsp_data, m_poll_count;

  int n_checks = 0;
  int n_fail   = 0;
  int a0_switch_j;

  logic s_cs [0:47];
  logic s_rd [0:47];
  logic s_a0 [0:47];
  logic s_rv [0:47];
  logic s_rdy[0:47];
  logic s_to [0:47];
  logic [7:0] s_data[0:47];
  logic [7:0] s_pc  [0:47];

  assign req_valid_a = req_valid & ~sel;
  assign req_valid_b = req_valid & sel;

  lcd_bus_reader dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_a0(req_a0), .req_poll(req_poll), .rsp_valid(rsp_valid_a),
    .rsp_data(rsp_data_a), .rsp_timeout(rsp_timeout_a), .poll_count(poll_count_a),
    .data_i(data_drv), .cs_n(cs_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a), .a0(a0_a),
    .bus_busy(bus_busy_a)
  );

  lcd_bus_reader #(.POLL_MAX(3)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_a0(req_a0), .req_poll(req_poll), .rsp_valid(rsp_valid_b),
    .rsp_data(rsp_data_b), .rsp_timeout(rsp_timeout_b), .poll_count(poll_count_b),
    .data_i(data_drv), .cs_n(cs_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b), .a0(a0_b),
    .bus_busy(bus_busy_b)
  );

  always_comb begin
    m_req_ready   = sel ? req_ready_b   : req_ready_a;
    m_rsp_valid   = sel ? rsp_valid_b   : rsp_valid_a;
    m_rsp_timeout = sel ? rsp_timeout_b : rsp_timeout_a;
    m_cs_n        = sel ? cs_n_b        : cs_n_a;
    m_rd_n        = sel ? rd_n_b        : rd_n_a;
    m_a0          = sel ? a0_b          : a0_a;
    m_bus_busy    = sel ? bus_busy_b    : bus_busy_a;
    m_rsp_data    = sel ? rsp_data_b    : rsp_data_a;
    m_poll_count  = sel ? poll_count_b  : poll_count_a;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("wr_n_a", wr_n_a, 1);
      check_eq("wr_n_b", wr_n_b, 1);
      check_eq("busy_vs_state_a", bus_busy_a, dut_a.state_q != ST_IDLE);
      check_eq("busy_vs_state_b", bus_busy_b, dut_b.state_q != ST_IDLE);
    end
  end

  task automatic issue(input bit use_b, input bit a0v, input bit pollv, input bit hold);
    int waited = 0;
    sel = use_b;
    @(negedge clk);
    while (!m_req_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check_eq("req_ready_before_issue", m_req_ready, 1);
    req_a0    = a0v;
    req_poll  = pollv;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    int reads = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == a0_switch_j) req_a0 = 1'b0;
      s_cs[j] = m_cs_n;  s_rd[j] = m_rd_n;  s_a0[j] = m_a0;  s_rv[j] = m_rsp_valid;
      s_rdy[j] = m_req_ready;  s_to[j] = m_rsp_timeout;
      s_data[j] = m_rsp_data;  s_pc[j] = m_poll_count;
      if (poll_seq && j > 0 && !s_rd[j-1] && s_rd[j]) begin
        reads++;
        if (reads >= 2) data_drv = 8'h00;
      end
    end
  endtask

  function automatic int cnt_cs_low(int lo, int hi);
    int c = 0;
    for (int j = lo; j <= hi; j++) if (!s_cs[j]) c++;
    return c;
  endfunction

  function automatic int cnt_rd_low(int lo, int hi);
    int c = 0;
    for (int j = lo; j <= hi; j++) if (!s_rd[j]) c++;
    return c;
  endfunction

  function automatic int cnt_rv(int lo, int hi);
    int c = 0;
    for (int j = lo; j <= hi; j++) if (s_rv[j]) c++;
    return c;
  endfunction

  function automatic int cnt_strobes(int lo, int hi);
    int c = 0;
    for (int j = lo + 1; j <= hi; j++) if (s_rd[j-1] && !s_rd[j]) c++;
    return c;
  endfunction

  function automatic int first_rv(int lo, int hi);
    for (int j = lo; j <= hi; j++) if (s_rv[j]) return j;
    return -1;
  endfunction

  function automatic int first_rdy(int lo, int hi);
    for (int j = lo; j <= hi; j++) if (s_rdy[j]) return j;
    return -1;
  endfunction

  function automatic int first_cs_low(int lo, int hi);
    for (int j = lo; j <= hi; j++) if (!s_cs[j]) return j;
    return -1;
  endfunction

  function automatic int a0_bad(int lo, int hi, logic exp);
    int c = 0;
    for (int j = lo; j <= hi; j++) if (!s_cs[j] && s_a0[j] !== exp) c++;
    return c;
  endfunction

  function automatic int rv_doubles(int lo, int hi);
    int c = 0;
    for (int j = lo + 1; j <= hi; j++) if (s_rv[j-1] && s_rv[j]) c++;
    return c;
  endfunction

  initial begin
    mon_en = 1'b0; poll_seq = 1'b0; a0_switch_j = -1;
    rst = 1'b1; req_valid = 1'b0; req_a0 = 1'b0; req_poll = 1'b0; sel = 1'b0;
    data_drv = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_cs_n", cs_n_a, 1);
    check_eq("rst_rd_n", rd_n_a, 1);
    check_eq("rst_wr_n", wr_n_a, 1);
    check_eq("rst_a0", a0_a, 0);
    check_eq("rst_req_ready", req_ready_a, 0);
    check_eq("rst_rsp_valid", rsp_valid_a, 0);
    check_eq("rst_rsp_data", rsp_data_a, 8'h00);
    check_eq("rst_rsp_timeout", rsp_timeout_a, 0);
    check_eq("rst_poll_count", poll_count_a, 0);
    check_eq("rst_bus_busy", bus_busy_a, 0);
    check_eq("rst_req_ready_b", req_ready_b, 0);
    mon_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_req_ready", req_ready_a, 1);

    // single data read
    data_drv = 8'hA5;
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    capture(10);
    check_eq("sr_cs_low_cycles", cnt_cs_low(0, 9), 6);
    check_eq("sr_rd_low_cycles", cnt_rd_low(0, 9), 4);
    check_eq("sr_first_strobe", s_rd[1], 0);
    check_eq("sr_a0_bad", a0_bad(0, 9, 1'b1), 0);
    check_eq("sr_rsp_idx", first_rv(0, 9), 6);
    check_eq("sr_rsp_count", cnt_rv(0, 9), 1);
    check_eq("sr_rsp_data", s_data[6], 8'hA5);
    check_eq("sr_rsp_timeout", s_to[6], 0);
    check_eq("sr_poll_count", s_pc[6], 1);
    check_eq("sr_ready_idx", first_rdy(0, 9), 8);
    check_eq("sr_data_held", s_data[9], 8'hA5);

    // status poll: busy, busy, ready (a0 request ignored in poll mode)
    data_drv = 8'h80; poll_seq = 1'b1;
    issue(1'b0, 1'b1, 1'b1, 1'b0);
    capture(26);
    poll_seq = 1'b0;
    check_eq("poll_strobes", cnt_strobes(0, 25), 3);
    check_eq("poll_a0_bad", a0_bad(0, 25, 1'b0), 0);
    check_eq("poll_rsp_count", cnt_rv(0, 25), 1);
    check_eq("poll_rsp_idx", first_rv(0, 25), 22);
    check_eq("poll_rsp_data", s_data[22], 8'h00);
    check_eq("poll_count", s_pc[22], 3);
    check_eq("poll_timeout", s_to[22], 0);
    check_eq("poll_ready_idx", first_rdy(0, 25), 24);

    // poll timeout on the POLL_MAX=3 instance
    data_drv = 8'hFF;
    issue(1'b1, 1'b0, 1'b1, 1'b0);
    capture(26);
    check_eq("to_strobes", cnt_strobes(0, 25), 3);
    check_eq("to_rsp_count", cnt_rv(0, 25), 1);
    check_eq("to_rsp_idx", first_rv(0, 25), 22);
    check_eq("to_timeout", s_to[22], 1);
    check_eq("to_rsp_data", s_data[22], 8'hFF);
    check_eq("to_poll_count", s_pc[22], 3);

    // back-to-back with req_valid held; a0 request changes mid-transaction
    data_drv = 8'h3C; a0_switch_j = 2;
    issue(1'b0, 1'b1, 1'b0, 1'b1);
    capture(20);
    req_valid = 1'b0; a0_switch_j = -1;
    check_eq("b2b_first_a0_bad", a0_bad(0, 5, 1'b1), 0);
    check_eq("b2b_second_setup", first_cs_low(6, 19), 9);
    check_eq("b2b_second_a0", s_a0[9], 0);
    check_eq("b2b_rsp_count", cnt_rv(0, 19), 2);
    check_eq("b2b_rsp_second_idx", first_rv(7, 19), 15);
    check_eq("b2b_rsp_one_cycle", rv_doubles(0, 19), 0);
    check_eq("b2b_rsp_data", s_data[15], 8'h3C);

    // reset on the 2nd STROBE cycle
    data_drv = 8'h5A;
    issue(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("mr_in_strobe", rd_n_a, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mr_cs_n", cs_n_a, 1);
    check_eq("mr_rd_n", rd_n_a, 1);
    check_eq("mr_bus_busy", bus_busy_a, 0);
    check_eq("mr_rsp_valid", rsp_valid_a, 0);
    rst = 1'b0;
    capture(12);
    check_eq("mr_ready_idx", first_rdy(0, 11), 0);
    check_eq("mr_no_rsp", cnt_rv(0, 11), 0);
    check_eq("mr_no_strobe", cnt_rd_low(0, 11), 0);
    check_eq("mr_rsp_data", s_data[11], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
